// File: rtl/serdesphy_pma_pwr_seq_if.sv
// Control/status bundle between the PMA power sequencer, its requesters and the PMA analog macro.
// master: request side (phy_en, bypass, fault_clr, raw PMA status); slave: the sequencer.
interface serdesphy_pma_pwr_seq_if;
  logic       phy_en;
  logic       pll_bypass_en;
  logic       fault_clr;
  logic       pll_lock_raw;
  logic       pll_vco_ok;
  logic       pll_cp_ok;
  logic       analog_iso_n;
  logic       analog_reset_n;
  logic       pll_iso_n;
  logic       pll_enable;
  logic       pll_reset_n;
  logic       pll_lock;
  logic       phy_ready;
  logic       seq_fault;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  modport master (
    output phy_en, pll_bypass_en, fault_clr, pll_lock_raw, pll_vco_ok, pll_cp_ok,
    input  analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n,
    input  pll_lock, phy_ready, seq_fault, seq_state, retry_cnt
  );

  modport slave (
    input  phy_en, pll_bypass_en, fault_clr, pll_lock_raw, pll_vco_ok, pll_cp_ok,
    output analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n,
    output pll_lock, phy_ready, seq_fault, seq_state, retry_cnt
  );
endinterface

// File: rtl/serdesphy_pma_pwr_seq.sv
// PMA power-up / PLL-lock sequencer on the 24 MHz reference clock; outputs registered, 2-cycle status sync.
// Define SERDESPHY_PWRSEQ_RETRY_EN to retry PLL reset on lock timeout/loss before declaring FAULT.
module serdesphy_pma_pwr_seq #(
  parameter int ISO_DLY_CYC      = 24,
  parameter int PLL_RST_CYC      = 240,
  parameter int LOCK_TIMEOUT_CYC = 2400,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int LOSS_CYC         = 8,
  parameter int MAX_RETRY        = 3,
  parameter int TMR_W            = 12
) (
  input logic                   clk_ref_24m,
  input logic                   rst_n,
  serdesphy_pma_pwr_seq_if.slave pma
);

`ifdef SERDESPHY_PWRSEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [TMR_W-1:0] ISO_LAST     = TMR_W'(ISO_DLY_CYC - 1);
  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] LOSS_LAST    = TMR_W'(LOSS_CYC - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_ISO_REL   = 3'd1,
    ST_PLL_RST   = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // ctrl bit order: {analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n}
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] stable_q, stable_d;
  logic [TMR_W-1:0] loss_q, loss_d;
  logic [1:0]       retry_q, retry_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic [2:0]       sync1_q, sync2_q;
  logic             lock_qual;
  logic             lock_fail;
  logic             timed;

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pma.pll_lock_raw, pma.pll_vco_ok, pma.pll_cp_ok};
      sync2_q <= sync1_q;
    end
  end

  assign lock_qual = &sync2_q;

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      timer_q  <= '0;
      stable_q <= '0;
      loss_q   <= '0;
      retry_q  <= '0;
      ctrl_q   <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      loss_q   <= loss_d;
      retry_q  <= retry_d;
      ctrl_q   <= ctrl_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    lock_fail = 1'b0;

    case (state_q)
      ST_OFF:       if (pma.phy_en) state_d = ST_ISO_REL;
      ST_ISO_REL:   if (timer_q == ISO_LAST) state_d = ST_PLL_RST;
      ST_PLL_RST:   if (timer_q == RST_LAST) state_d = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        // Completed qualification takes precedence over a coincident timeout.
        if (pma.pll_bypass_en || (lock_qual && stable_q == STABLE_LAST)) begin
          state_d = ST_READY;
        end else if (timer_q == TIMEOUT_LAST) begin
          lock_fail = 1'b1;
        end
      end
      ST_READY: begin
        if (!pma.pll_bypass_en && !lock_qual && loss_q == LOSS_LAST) lock_fail = 1'b1;
      end
      ST_FAULT: begin
        if (pma.fault_clr) begin
          state_d = ST_OFF;
          retry_d = '0;
        end
      end
      default:      state_d = ST_OFF;
    endcase

    if (lock_fail) begin
      if (RETRY_EN && retry_q < RETRY_MAX) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_PLL_RST;
      end else begin
        state_d = ST_FAULT;
      end
    end

    // Dropping the request aborts everything except a latched fault.
    if (!pma.phy_en && state_q != ST_FAULT) state_d = ST_OFF;
    if (state_d == ST_OFF) retry_d = '0;
  end

  always_comb begin
    timed = (state_q == ST_ISO_REL) || (state_q == ST_PLL_RST) || (state_q == ST_LOCK_WAIT);
    timer_d  = (timed && state_d == state_q) ? timer_q + 1'b1 : '0;
    stable_d = (state_q == ST_LOCK_WAIT && state_d == ST_LOCK_WAIT && lock_qual)
               ? stable_q + 1'b1 : '0;
    loss_d   = (state_q == ST_READY && state_d == ST_READY && !lock_qual && !pma.pll_bypass_en)
               ? loss_q + 1'b1 : '0;
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    ctrl_d  = 5'b00000;
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_ISO_REL:   ctrl_d = 5'b10100;
      ST_PLL_RST:   ctrl_d = 5'b11110;
      ST_LOCK_WAIT: ctrl_d = 5'b11111;
      ST_READY: begin
        ctrl_d  = 5'b11111;
        ready_d = 1'b1;
      end
      ST_FAULT:     fault_d = 1'b1;
      default:      ctrl_d = 5'b00000;
    endcase
  end

  assign pma.analog_iso_n   = ctrl_q[4];
  assign pma.analog_reset_n = ctrl_q[3];
  assign pma.pll_iso_n      = ctrl_q[2];
  assign pma.pll_enable     = ctrl_q[1];
  assign pma.pll_reset_n    = ctrl_q[0];
  assign pma.pll_lock       = ready_q;
  assign pma.phy_ready      = ready_q;
  assign pma.seq_fault      = fault_q;
  assign pma.seq_state      = state_q;
  assign pma.retry_cnt      = retry_q;

endmodule

// File: tb/tb_serdesphy_pma_pwr_seq.sv
// Directed, table-driven bench for the PMA power sequencer; expectations hand-derived from the cycle timing.
// Builds with or without SERDESPHY_PWRSEQ_RETRY_EN; expectations follow the macro.
module tb_serdesphy_pma_pwr_seq;

`ifdef SERDESPHY_PWRSEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam logic [4:0] C_OFF = 5'b00000;
  localparam logic [4:0] C_ISO = 5'b10100;
  localparam logic [4:0] C_RST = 5'b11110;
  localparam logic [4:0] C_ALL = 5'b11111;

  typedef struct {
    bit         phy_en;
    bit         bypass;
    bit         lock;
    int         adv;
    logic [2:0] st;
    logic [4:0] ctrl;
    bit         ready;
    bit         fault;
    logic [1:0] retry;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[11];

  serdesphy_pma_pwr_seq_if pma_if();

  serdesphy_pma_pwr_seq dut (
    .clk_ref_24m (clk),
    .rst_n       (rst_n),
    .pma         (pma_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [4:0] ctrl,
                         input bit ready, input bit fault, input logic [1:0] retry);
    chk({tag, ".state"}, 32'(pma_if.seq_state), 32'(st));
    chk({tag, ".ctrl"}, 32'({pma_if.analog_iso_n, pma_if.analog_reset_n, pma_if.pll_iso_n,
                             pma_if.pll_enable, pma_if.pll_reset_n}), 32'(ctrl));
    chk({tag, ".ready"}, 32'(pma_if.phy_ready), 32'(ready));
    chk({tag, ".lock"}, 32'(pma_if.pll_lock), 32'(ready));
    chk({tag, ".fault"}, 32'(pma_if.seq_fault), 32'(fault));
    chk({tag, ".retry"}, 32'(pma_if.retry_cnt), 32'(retry));
  endtask

  // From OFF with phy_en rising now, LOCK_WAIT is entered 1+24+240 edges later.
  task automatic bring_to_lockwait(input string tag);
    pma_if.phy_en = 1'b1;
    step(265);
    chk({tag, ".lw_entry"}, 32'(pma_if.seq_state), 32'd3);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1,   3'd1, C_ISO, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 23,  3'd1, C_ISO, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1,   3'd2, C_RST, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 239, 3'd2, C_RST, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1,   3'd3, C_ALL, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 63,  3'd3, C_ALL, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1,   3'd4, C_ALL, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 7,   3'd4, C_ALL, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 10,  3'd4, C_ALL, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 9,   3'd4, C_ALL, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1,   RETRY ? 3'd2 : 3'd5, RETRY ? C_RST : C_OFF,
                 1'b0, !RETRY, RETRY ? 2'd1 : 2'd0};

    rst_n                = 1'b0;
    pma_if.phy_en        = 1'b0;
    pma_if.pll_bypass_en = 1'b0;
    pma_if.fault_clr     = 1'b0;
    pma_if.pll_lock_raw  = 1'b0;
    pma_if.pll_vco_ok    = 1'b1;
    pma_if.pll_cp_ok     = 1'b1;
    step(3);
    chk_all("reset", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    step(2);
    chk_all("idle", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);

    // Nominal bring-up, READY glitch tolerance, then an 8-cycle lock loss.
    for (int i = 0; i < 11; i++) begin
      pma_if.phy_en        = vecs[i].phy_en;
      pma_if.pll_bypass_en = vecs[i].bypass;
      pma_if.pll_lock_raw  = vecs[i].lock;
      step(vecs[i].adv);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].ready,
              vecs[i].fault, vecs[i].retry);
    end

    // phy_en low: OFF with retry cleared, unless latched in FAULT.
    pma_if.phy_en = 1'b0;
    step(1);
    chk_all("drop_after_loss", RETRY ? 3'd0 : 3'd5, C_OFF, 1'b0, !RETRY, 2'd0);
    pma_if.fault_clr = 1'b1;
    step(1);
    pma_if.fault_clr = 1'b0;
    chk_all("clr_after_loss", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);

    // Abort in PLL_RST at timer 100; re-enable restarts the timers from zero.
    pma_if.phy_en       = 1'b1;
    pma_if.pll_lock_raw = 1'b1;
    step(125);
    chk_all("mid_rst", 3'd2, C_RST, 1'b0, 1'b0, 2'd0);
    pma_if.phy_en = 1'b0;
    step(1);
    chk_all("mid_abort", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);
    pma_if.phy_en = 1'b1;
    step(24);
    chk_all("restart_iso", 3'd1, C_ISO, 1'b0, 1'b0, 2'd0);
    step(1);
    chk_all("restart_rst", 3'd2, C_RST, 1'b0, 1'b0, 2'd0);
    pma_if.phy_en       = 1'b0;
    pma_if.pll_lock_raw = 1'b0;
    step(3);

    // Chatter: 63 qualified cycles, one VCO dropout, then 64 -> READY only after the second run.
    bring_to_lockwait("chatter");
    pma_if.pll_lock_raw = 1'b1;
    step(63);
    pma_if.pll_vco_ok = 1'b0;
    step(1);
    pma_if.pll_vco_ok = 1'b1;
    step(65);
    chk_all("chatter_wait", 3'd3, C_ALL, 1'b0, 1'b0, 2'd0);
    step(1);
    chk_all("chatter_ready", 3'd4, C_ALL, 1'b1, 1'b0, 2'd0);
    pma_if.phy_en       = 1'b0;
    pma_if.pll_lock_raw = 1'b0;
    step(1);
    chk_all("chatter_off", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);
    step(3);

    // Lock never arrives: timeout after 2400 LOCK_WAIT cycles, retried when enabled.
    bring_to_lockwait("nolock");
    for (int r = 1; r <= (RETRY ? 3 : 0); r++) begin
      step(2400);
      chk_all($sformatf("retry%0d_rst", r), 3'd2, C_RST, 1'b0, 1'b0, 2'(r));
      step(240);
      chk_all($sformatf("retry%0d_lw", r), 3'd3, C_ALL, 1'b0, 1'b0, 2'(r));
    end
    step(2399);
    chk_all("timeout_edge", 3'd3, C_ALL, 1'b0, 1'b0, RETRY ? 2'd3 : 2'd0);
    step(1);
    chk_all("timeout_fault", 3'd5, C_OFF, 1'b0, 1'b1, RETRY ? 2'd3 : 2'd0);
    step(5);
    chk_all("fault_hold", 3'd5, C_OFF, 1'b0, 1'b1, RETRY ? 2'd3 : 2'd0);
    pma_if.fault_clr = 1'b1;
    step(1);
    pma_if.fault_clr = 1'b0;
    chk_all("fault_clr", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);
    pma_if.phy_en = 1'b0;
    step(2);

    // Bypass: READY one cycle after LOCK_WAIT entry, immune to missing lock.
    pma_if.pll_bypass_en = 1'b1;
    bring_to_lockwait("bypass");
    step(1);
    chk_all("bypass_ready", 3'd4, C_ALL, 1'b1, 1'b0, 2'd0);
    step(5000);
    chk_all("bypass_hold", 3'd4, C_ALL, 1'b1, 1'b0, 2'd0);

    // Asynchronous reset between clock edges clears everything immediately.
    #1 rst_n = 1'b0;
    #1 chk_all("async_rst", 3'd0, C_OFF, 1'b0, 1'b0, 2'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
